// File: rtl/sort_feeder_pkg.sv
// Shared sizing defaults and counter-width helpers for the sort feeder.
// The macro defaults stand in for the shared configuration header when it is absent.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef NUM_DATA
`define NUM_DATA 8
`endif

package sort_feeder_pkg;

  // Counters must reach NUM_DATA itself, hence the extra bit.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_feeder.sv
// Loads NUM_DATA words, bubble-sorts them in place (one compare-swap per cycle, NUM_DATA-1 to (NUM_DATA-1)^2 cycles),
// then streams them ascending on wr_en/datain; output holds stable while out_ready is low, done is a level.
module sort_feeder
  import sort_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int NUM_DATA   = `NUM_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] datain,
  input  logic                  out_ready,
  output logic                  done
);

  localparam int CW = cnt_width(NUM_DATA);
  localparam int AW = idx_width(NUM_DATA);
  localparam logic [CW-1:0] LAST     = CW'(NUM_DATA - 1);
  localparam logic [CW-1:0] PASS_END = CW'(NUM_DATA - 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SORT = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state;
  logic [CW-1:0]           wr_cnt;
  logic [CW-1:0]           rd_cnt;
  logic [CW-1:0]           idx;
  logic [CW-1:0]           pass;
  logic                    swapped;
  logic [DATA_WIDTH-1:0]   buff [NUM_DATA];

  logic [AW-1:0]           ia;
  logic [AW-1:0]           ib;
  logic [AW-1:0]           rd_nx;
  logic [DATA_WIDTH-1:0]   word_a;
  logic [DATA_WIDTH-1:0]   word_b;
  logic [DATA_WIDTH-1:0]   first_word;
  logic                    do_swap;
  logic                    pass_end;
  logic                    sort_exit;
  logic                    load_acc;
  logic                    emit_acc;

  assign ia        = idx[AW-1:0];
  assign ib        = ia + AW'(1);
  assign rd_nx     = rd_cnt[AW-1:0] + AW'(1);
  assign word_a    = buff[ia];
  assign word_b    = buff[ib];
  assign do_swap   = (state == SORT) && (word_a > word_b);
  assign pass_end  = (idx == PASS_END);
  assign sort_exit = pass_end && (!(swapped || do_swap) || (pass == PASS_END));
  assign load_acc  = (state == LOAD) && in_valid && in_ready;
  assign emit_acc  = (state == EMIT) && wr_en && out_ready;
  // buff[0] may be swapped on the very edge SORT exits (only when idx is 0).
  assign first_word = (do_swap && (ia == '0)) ? word_b : buff[0];

  // Storage is not reset; writes are simply suppressed while rst is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (load_acc) begin
        buff[wr_cnt[AW-1:0]] <= in_data;
      end else if (do_swap) begin
        buff[ia] <= word_b;
        buff[ib] <= word_a;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      datain   <= '0;
      done     <= 1'b0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      idx      <= '0;
      pass     <= '0;
      swapped  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            wr_cnt   <= '0;
            done     <= 1'b0;
          end
        end
        LOAD: begin
          if (load_acc) begin
            wr_cnt <= wr_cnt + CW'(1);
            if (wr_cnt == LAST) begin
              state    <= SORT;
              in_ready <= 1'b0;
              idx      <= '0;
              pass     <= '0;
              swapped  <= 1'b0;
            end
          end
        end
        SORT: begin
          if (sort_exit) begin
            state  <= EMIT;
            wr_en  <= 1'b1;
            rd_cnt <= '0;
            datain <= first_word;
          end else if (pass_end) begin
            pass    <= pass + CW'(1);
            idx     <= '0;
            swapped <= 1'b0;
          end else begin
            idx     <= idx + CW'(1);
            swapped <= swapped || do_swap;
          end
        end
        EMIT: begin
          if (emit_acc) begin
            if (rd_cnt == LAST) begin
              state <= DONE;
              wr_en <= 1'b0;
              done  <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + CW'(1);
              datain <= buff[rd_nx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
